// File: rtl/lift_pkg.sv
// Shared types for the hall call dispatcher: FSM state encoding, call-slot
// direction encoding and width helpers used by the dispatcher and the cost block.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_ISSUE = 2'd3
  } disp_state_t;

  // Slot s < n_floors is an up call at floor s; slot s >= n_floors is a down call at floor s - n_floors.
  typedef enum logic {
    CALL_DN = 1'b0,
    CALL_UP = 1'b1
  } call_dir_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cost_width(input int n_floors);
    return clog2_min1(n_floors) + 1;
  endfunction

  function automatic int slot_count(input int n_floors);
    return 2 * n_floors;
  endfunction

endpackage

// File: rtl/hall_call_dispatcher_if.sv
// Assignment handshake between the dispatcher (master) and the car controller (slave).
interface hall_call_dispatcher_if #(
  parameter int FW = 4,
  parameter int LW = 4
);
  logic          asg_valid;
  logic          asg_ready;
  logic [LW-1:0] asg_lift;
  logic [FW-1:0] asg_floor;
  logic          asg_dir;

  modport master (
    output asg_valid,
    output asg_lift,
    output asg_floor,
    output asg_dir,
    input  asg_ready
  );

  modport slave (
    input  asg_valid,
    input  asg_lift,
    input  asg_floor,
    input  asg_dir,
    output asg_ready
  );
endinterface

// File: rtl/lift_cost_calc.sv
// Combinational cost of sending one lift to one hall call: floor distance, plus a
// one-building penalty when a moving lift is heading the wrong way or has passed the call.
module lift_cost_calc
  import lift_pkg::*;
#(
  parameter  int N_FLOORS = 12,
  localparam int FW = clog2_min1(N_FLOORS),
  localparam int CW = cost_width(N_FLOORS)
) (
  input  logic [FW-1:0] lift_floor,
  input  logic [FW-1:0] call_floor,
  input  logic          lift_dir,
  input  logic          call_dir,
  input  logic          lift_moving,
  output logic [CW-1:0] cost
);

  localparam logic [CW-1:0] PENALTY = CW'(N_FLOORS);

  logic [FW-1:0] abs_diff;
  logic          behind;
  logic          penalty;

  always_comb begin
    abs_diff = (lift_floor >= call_floor) ? (lift_floor - call_floor) : (call_floor - lift_floor);
    behind   = lift_dir ? (call_floor < lift_floor) : (call_floor > lift_floor);
    penalty  = lift_moving && ((lift_dir != call_dir) || behind);
    cost     = {1'b0, abs_diff} + (penalty ? PENALTY : '0);
  end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Hall call dispatcher: latches hall calls, picks them round-robin and assigns each to
// the cheapest available lift. Define DISPATCH_STATUS_EN to expose pending calls for hall lamps.
module hall_call_dispatcher
  import lift_pkg::*;
#(
  parameter  int N_FLOORS = 12,
  parameter  int N_LIFTS  = 10,
  localparam int FW = clog2_min1(N_FLOORS),
  localparam int LW = clog2_min1(N_LIFTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_FLOORS-1:0]   up_rqst,
  input  logic [N_FLOORS-1:0]   dn_rqst,
  input  logic [N_LIFTS*FW-1:0] lift_floor,
  input  logic [N_LIFTS-1:0]    direction,
  input  logic [N_LIFTS-1:0]    motion,
  input  logic [N_LIFTS-1:0]    lift_avail,
  input  logic [N_FLOORS-1:0]   served_up,
  input  logic [N_FLOORS-1:0]   served_dn,
  hall_call_dispatcher_if.master asg
`ifdef DISPATCH_STATUS_EN
  ,
  output logic [N_FLOORS-1:0]   up_rqst_status,
  output logic [N_FLOORS-1:0]   dn_rqst_status
`endif
);

  localparam int NS = slot_count(N_FLOORS);
  localparam int SW = clog2_min1(NS);
  localparam int CW = cost_width(N_FLOORS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NS - 1);
  localparam logic [LW-1:0] LAST_LIFT = LW'(N_LIFTS - 1);

  disp_state_t   state_reg, state_next;
  logic [N_FLOORS-1:0] pending_up_reg, pending_dn_reg, assigned_up_reg, assigned_dn_reg;
  logic [SW-1:0] rr_reg, rr_next;
  logic [SW-1:0] slot_reg, slot_next;
  logic [FW-1:0] slot_floor_reg, slot_floor_next;
  logic          slot_dir_reg, slot_dir_next;
  logic [LW-1:0] lift_idx_reg, lift_idx_next;
  logic          best_found_reg, best_found_next;
  logic [LW-1:0] best_lift_reg, best_lift_next;
  logic [CW-1:0] best_cost_reg, best_cost_next;

  logic [NS-1:0] eligible, served_all, assign_set;
  logic          scan_found, scan_dir, take;
  logic [SW-1:0] scan_slot, slot_inc;
  logic [FW-1:0] scan_floor;
  logic [CW-1:0] cost;
  logic [FW-1:0] floor_arr [N_LIFTS];

  for (genvar gi = 0; gi < N_LIFTS; gi++) begin : g_floor
    assign floor_arr[gi] = lift_floor[gi*FW +: FW];
  end

  assign eligible   = {pending_dn_reg & ~assigned_dn_reg, pending_up_reg & ~assigned_up_reg};
  assign served_all = {served_dn, served_up};
  assign slot_inc   = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;

  // First eligible slot at or after the round-robin pointer, wrapping around.
  always_comb begin
    int idx;
    scan_found = 1'b0;
    scan_slot  = '0;
    for (int i = 0; i < NS; i++) begin
      idx = int'(rr_reg) + i;
      if (idx >= NS) idx = idx - NS;
      if (!scan_found && eligible[idx]) begin
        scan_found = 1'b1;
        scan_slot  = SW'(idx);
      end
    end
    if (scan_slot < SW'(N_FLOORS)) begin
      scan_floor = FW'(scan_slot);
      scan_dir   = CALL_UP;
    end else begin
      scan_floor = FW'(scan_slot - SW'(N_FLOORS));
      scan_dir   = CALL_DN;
    end
  end

  lift_cost_calc #(.N_FLOORS(N_FLOORS)) u_cost (
    .lift_floor  (floor_arr[lift_idx_reg]),
    .call_floor  (slot_floor_reg),
    .lift_dir    (direction[lift_idx_reg]),
    .call_dir    (slot_dir_reg),
    .lift_moving (motion[lift_idx_reg]),
    .cost        (cost)
  );

  always_comb begin
    state_next      = state_reg;
    rr_next         = rr_reg;
    slot_next       = slot_reg;
    slot_floor_next = slot_floor_reg;
    slot_dir_next   = slot_dir_reg;
    lift_idx_next   = lift_idx_reg;
    best_found_next = best_found_reg;
    best_lift_next  = best_lift_reg;
    best_cost_next  = best_cost_reg;
    assign_set      = '0;
    take            = 1'b0;
    case (state_reg)
      ST_IDLE: if (|eligible) state_next = ST_SCAN;
      ST_SCAN: begin
        if (scan_found) begin
          slot_next       = scan_slot;
          slot_floor_next = scan_floor;
          slot_dir_next   = scan_dir;
          lift_idx_next   = '0;
          best_found_next = 1'b0;
          state_next      = ST_EVAL;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_EVAL: begin
        take = lift_avail[lift_idx_reg] && (!best_found_reg || (cost < best_cost_reg));
        if (take) begin
          best_found_next = 1'b1;
          best_lift_next  = lift_idx_reg;
          best_cost_next  = cost;
        end
        if (served_all[slot_reg]) begin
          rr_next    = slot_inc;
          state_next = ST_IDLE;
        end else if (lift_idx_reg == LAST_LIFT) begin
          if (best_found_next) begin
            state_next = ST_ISSUE;
          end else begin
            rr_next    = slot_inc;
            state_next = ST_IDLE;
          end
        end else begin
          lift_idx_next = lift_idx_reg + 1'b1;
        end
      end
      ST_ISSUE: begin
        if (served_all[slot_reg]) begin
          rr_next    = slot_inc;
          state_next = ST_IDLE;
        end else if (asg.asg_ready) begin
          assign_set[slot_reg] = 1'b1;
          rr_next              = slot_inc;
          state_next           = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A served pulse beats a simultaneous request or assignment for the same call.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      pending_up_reg  <= '0;
      pending_dn_reg  <= '0;
      assigned_up_reg <= '0;
      assigned_dn_reg <= '0;
      rr_reg          <= '0;
      slot_reg        <= '0;
      slot_floor_reg  <= '0;
      slot_dir_reg    <= 1'b0;
      lift_idx_reg    <= '0;
      best_found_reg  <= 1'b0;
      best_lift_reg   <= '0;
      best_cost_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      pending_up_reg  <= (pending_up_reg | up_rqst) & ~served_up;
      pending_dn_reg  <= (pending_dn_reg | dn_rqst) & ~served_dn;
      assigned_up_reg <= (assigned_up_reg | assign_set[N_FLOORS-1:0]) & ~served_up;
      assigned_dn_reg <= (assigned_dn_reg | assign_set[NS-1:N_FLOORS]) & ~served_dn;
      rr_reg          <= rr_next;
      slot_reg        <= slot_next;
      slot_floor_reg  <= slot_floor_next;
      slot_dir_reg    <= slot_dir_next;
      lift_idx_reg    <= lift_idx_next;
      best_found_reg  <= best_found_next;
      best_lift_reg   <= best_lift_next;
      best_cost_reg   <= best_cost_next;
    end
  end

  assign asg.asg_valid = (state_reg == ST_ISSUE);
  assign asg.asg_lift  = best_lift_reg;
  assign asg.asg_floor = slot_floor_reg;
  assign asg.asg_dir   = slot_dir_reg;

`ifdef DISPATCH_STATUS_EN
  assign up_rqst_status = pending_up_reg;
  assign dn_rqst_status = pending_dn_reg;
`endif

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed self-checking bench for hall_call_dispatcher (12 floors, 10 lifts).
module tb_hall_call_dispatcher;

  localparam int NF = 12;
  localparam int NL = 10;
  localparam int FW = 4;
  localparam int LW = 4;

  logic           clk;
  logic           reset;
  logic [NF-1:0]  up_rqst, dn_rqst, served_up, served_dn;
  logic [NL*FW-1:0] lift_floor;
  logic [NL-1:0]  direction, motion, lift_avail;
`ifdef DISPATCH_STATUS_EN
  logic [NF-1:0]  up_status, dn_status;
`endif

  int checks = 0;
  int errors = 0;

  hall_call_dispatcher_if #(.FW(FW), .LW(LW)) asg ();

  hall_call_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .up_rqst    (up_rqst),
    .dn_rqst    (dn_rqst),
    .lift_floor (lift_floor),
    .direction  (direction),
    .motion     (motion),
    .lift_avail (lift_avail),
    .served_up  (served_up),
    .served_dn  (served_dn),
    .asg        (asg.master)
`ifdef DISPATCH_STATUS_EN
    ,
    .up_rqst_status (up_status),
    .dn_rqst_status (dn_status)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_lift(input int i, input int fl, input bit dir, input bit mov, input bit av);
    lift_floor[i*FW +: FW] = FW'(fl);
    direction[i]  = dir;
    motion[i]     = mov;
    lift_avail[i] = av;
  endtask

  task automatic all_lifts(input int fl, input bit av);
    for (int i = 0; i < NL; i++) set_lift(i, fl, 1'b0, 1'b0, av);
  endtask

  task automatic wait_valid(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      cyc++;
      if (asg.asg_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_valid(input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (asg.asg_valid) hi++;
    end
  endtask

  task automatic pulse_dn(input int f);
    dn_rqst[f] = 1'b1;
    @(negedge clk);
    dn_rqst = '0;
  endtask

  task automatic serve(input int f, input bit up);
    if (up) served_up[f] = 1'b1; else served_dn[f] = 1'b1;
    @(negedge clk);
    served_up = '0;
    served_dn = '0;
  endtask

  initial begin
    bit ok, ok2;
    int cyc, hi, stable;
    logic [FW-1:0] f1, f2;
    logic d1, d2;

    reset = 1'b0;
    up_rqst = '0; dn_rqst = '0; served_up = '0; served_dn = '0;
    lift_floor = '0; direction = '0; motion = '0; lift_avail = '0;
    asg.asg_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(asg.asg_valid), 0);
    check("reset_lift",  32'(asg.asg_lift),  0);
    check("reset_floor", 32'(asg.asg_floor), 0);
    check("reset_dir",   32'(asg.asg_dir),   0);
    reset = 1'b1;
    @(negedge clk);

    // Nearest idle lift, with latency counted from the request-sampling edge.
    all_lifts(11, 1'b1);
    set_lift(0, 0, 1'b0, 1'b0, 1'b1);
    set_lift(1, 4, 1'b0, 1'b0, 1'b1);
    set_lift(2, 9, 1'b0, 1'b0, 1'b1);
    asg.asg_ready = 1'b1;
    up_rqst[5] = 1'b1;
    @(negedge clk);
    up_rqst = '0;
    wait_valid(ok, cyc);
    check("t1_got_valid", 32'(ok), 1);
    check("t1_latency",   32'(cyc + 1), NL + 3);
    check("t1_lift",      32'(asg.asg_lift), 1);
    check("t1_floor",     32'(asg.asg_floor), 5);
    check("t1_dir",       32'(asg.asg_dir), 1);
    @(negedge clk);
    check("t1_valid_drop", 32'(asg.asg_valid), 0);
    up_rqst[5] = 1'b1;
    @(negedge clk);
    up_rqst = '0;
    count_valid(NL + 8, hi);
    check("t1_no_reissue", 32'(hi), 0);
    serve(5, 1'b1);

    // Equal-cost lifts: lowest index wins.
    all_lifts(0, 1'b1);
    set_lift(2, 7, 1'b0, 1'b0, 1'b1);
    set_lift(3, 7, 1'b0, 1'b0, 1'b1);
    pulse_dn(7);
    wait_valid(ok, cyc);
    check("t2_got_valid", 32'(ok), 1);
    check("t2_lift",      32'(asg.asg_lift), 2);
    check("t2_floor",     32'(asg.asg_floor), 7);
    check("t2_dir",       32'(asg.asg_dir), 0);
    serve(7, 1'b0);

    // Moving lift heading the wrong way takes the penalty.
    all_lifts(0, 1'b0);
    set_lift(0, 3, 1'b1, 1'b1, 1'b1);
    set_lift(1, 8, 1'b0, 1'b0, 1'b1);
    pulse_dn(2);
    wait_valid(ok, cyc);
    check("t3_got_valid", 32'(ok), 1);
    check("t3_lift",      32'(asg.asg_lift), 1);
    check("t3_floor",     32'(asg.asg_floor), 2);
    check("t3_dir",       32'(asg.asg_dir), 0);
    serve(2, 1'b0);

    // Held offer withdrawn when the call is served elsewhere.
    all_lifts(0, 1'b1);
    asg.asg_ready = 1'b0;
    up_rqst[5] = 1'b1;
    @(negedge clk);
    up_rqst = '0;
    wait_valid(ok, cyc);
    check("t4_got_valid", 32'(ok), 1);
    stable = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (asg.asg_valid && asg.asg_lift == 0 && asg.asg_floor == 5 && asg.asg_dir) stable++;
    end
    check("t4_held_stable", 32'(stable), 20);
    served_up[5] = 1'b1;
    @(negedge clk);
    served_up = '0;
    check("t4_valid_dropped", 32'(asg.asg_valid), 0);
`ifdef DISPATCH_STATUS_EN
    check("t4_status_cleared", 32'(up_status[5]), 0);
`endif
    count_valid(NL + 8, hi);
    check("t4_pending_cleared", 32'(hi), 0);

    // Up and down call on the same floor, from a fresh pointer.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    asg.asg_ready = 1'b1;
    up_rqst[3] = 1'b1;
    dn_rqst[3] = 1'b1;
    @(negedge clk);
    up_rqst = '0;
    dn_rqst = '0;
    wait_valid(ok, cyc);
    f1 = asg.asg_floor;
    d1 = asg.asg_dir;
    wait_valid(ok2, cyc);
    f2 = asg.asg_floor;
    d2 = asg.asg_dir;
    check("t5_got_both", 32'(ok & ok2), 1);
    check("t5_first_floor",  32'(f1), 3);
    check("t5_first_dir",    32'(d1), 1);
    check("t5_second_floor", 32'(f2), 3);
    check("t5_second_dir",   32'(d2), 0);
    @(negedge clk);
    served_up[3] = 1'b1;
    served_dn[3] = 1'b1;
    @(negedge clk);
    served_up = '0;
    served_dn = '0;

    // No available lift, then one becomes available; then reset mid-evaluation.
    all_lifts(0, 1'b0);
    pulse_dn(1);
    count_valid(NL + 10, hi);
    check("t6_no_lift_no_valid", 32'(hi), 0);
    lift_avail[4] = 1'b1;
    wait_valid(ok, cyc);
    check("t6_got_valid", 32'(ok), 1);
    check("t6_lift",  32'(asg.asg_lift), 4);
    check("t6_floor", 32'(asg.asg_floor), 1);
    check("t6_dir",   32'(asg.asg_dir), 0);
    @(negedge clk);
    serve(1, 1'b0);
    dn_rqst[2] = 1'b1;
    @(negedge clk);
    dn_rqst = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(asg.asg_valid), 0);
    check("t6_rst_lift",  32'(asg.asg_lift),  0);
    check("t6_rst_floor", 32'(asg.asg_floor), 0);
    check("t6_rst_dir",   32'(asg.asg_dir),   0);
    @(negedge clk);
    reset = 1'b1;
    count_valid(NL + 10, hi);
    check("t6_inflight_discarded", 32'(hi), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hall_call_dispatcher.md
HALL_CALL_DISPATCHER -- requirements
Module: hall_call_dispatcher

Interface
REQ-001 SHALL have parameter N_FLOORS, default 12, number of floors served.
REQ-002 SHALL have parameter N_LIFTS, default 10, number of lift cars dispatched.
REQ-003 SHALL define local FW = $clog2(N_FLOORS) and LW = $clog2(N_LIFTS), both minimum 1.
REQ-004 clk  in  1  single system clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 up_rqst  in  N_FLOORS  hall up-button per floor, level or pulse.
REQ-007 dn_rqst  in  N_FLOORS  hall down-button per floor, level or pulse.
REQ-008 lift_floor  in  N_LIFTS*FW  binary last-passed floor per lift; lift i occupies bits [i*FW +: FW].
REQ-009 direction  in  N_LIFTS  per-lift heading, 1 = up.
REQ-010 motion  in  N_LIFTS  per-lift moving flag.
REQ-011 lift_avail  in  N_LIFTS  lift may accept new hall calls.
REQ-012 served_up / served_dn  in  N_FLOORS each  one-cycle pulse: the call at that floor and direction has been answered.
REQ-013 asg_valid  out  1  assignment offered.
REQ-014 asg_ready  in  1  assignment accepted.
REQ-015 asg_lift  out  LW; asg_floor  out  FW; asg_dir  out  1 (1 = up).

Function
REQ-016 SHALL keep pending_up/pending_dn and assigned_up/assigned_dn registers, N_FLOORS bits each.
REQ-017 A request bit high SHALL set the matching pending bit on the next edge, unless the matching served bit is high in the same cycle; served wins and clears both pending and assigned.
REQ-018 SHALL run FSM IDLE -> SCAN -> EVAL -> ISSUE -> IDLE.
REQ-019 Call slots 0..N_FLOORS-1 SHALL be up calls and N_FLOORS..2*N_FLOORS-1 SHALL be down calls; a 2*N_FLOORS-wide round-robin pointer rr SHALL reset to 0.
REQ-020 IDLE SHALL move to SCAN when any pending-and-not-assigned bit is set.
REQ-021 SCAN SHALL, in one cycle, latch the first eligible slot at or after rr (wrapping) and enter EVAL with lift index 0.
REQ-022 EVAL SHALL visit one lift per cycle for exactly N_LIFTS cycles.
REQ-023 Cost SHALL be FW+1 bits: |lift_floor - call_floor|.
REQ-024 Cost SHALL add N_FLOORS when the lift is in motion and either its direction differs from the call direction or the call lies behind it.
REQ-025 Unavailable lifts SHALL be skipped; strictly lower cost SHALL replace the best candidate, so ties keep the lowest index.
REQ-026 After the last lift, EVAL SHALL go to ISSUE if any candidate was found; otherwise it SHALL advance rr to slot+1 and return to IDLE.
REQ-027 ISSUE SHALL hold asg_valid=1 with stable asg_lift/asg_floor/asg_dir until asg_valid && asg_ready.
REQ-028 On that handshake the dispatcher SHALL set the slot's assigned bit, set rr = slot+1 mod 2*N_FLOORS and go to IDLE.
REQ-029 If the latched slot is served during EVAL or ISSUE, the dispatcher SHALL drop asg_valid on the next cycle, advance rr and return to IDLE without a handshake.
REQ-030 Latency from request edge to asg_valid SHALL be N_LIFTS+3 cycles with the FSM initially idle.
REQ-031 An assigned call SHALL never be reissued until it is served and requested again.

Reset
REQ-032 reset low SHALL asynchronously clear pending, assigned, rr, FSM (to IDLE), best-candidate registers, asg_valid, asg_lift, asg_floor and asg_dir to 0.
REQ-033 Reset mid-EVAL or mid-ISSUE SHALL discard the in-flight assignment.

Configuration
REQ-034 With DISPATCH_STATUS_EN defined, outputs up_rqst_status/dn_rqst_status (N_FLOORS each) SHALL drive pending_up/pending_dn for hall lamps; without it these ports SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-035 Package lift_pkg SHALL hold the dispatcher state enum, the call-slot encoding and the cost-width helper function.
REQ-036 Cost computation SHALL be a combinational sub-module lift_cost_calc, instantiated once and shared across EVAL cycles.

Verification
REQ-037 up_rqst[5] pulse; lifts idle at floors 0, 4, 9, all available; asg_ready=1 -> asg_valid at cycle N_LIFTS+3 with lift 1, floor 5, dir 1.
REQ-038 Lifts 2 and 3 both idle at floor 7; dn_rqst[7] -> asg_lift=2 (lowest-index tie-break).
REQ-039 Lift 0 at floor 3 moving up, lift 1 idle at floor 8; dn_rqst[2] -> asg_lift=1 (cost 6 < 1+12).
REQ-040 asg_ready held 0 for 20 cycles, then served_up[5] -> asg_valid drops next cycle, no handshake, pending_up[5]=0.
REQ-041 up_rqst[3] and dn_rqst[3] simultaneous -> two assignments issued, up first, in consecutive dispatches.
REQ-042 lift_avail=0, dn_rqst[1] -> no asg_valid; later set lift_avail[4]=1 -> assignment to lift 4; assert reset mid-EVAL -> all outputs 0.
